// File: rtl/trng_ctrl.sv
`default_nettype none
// ==========================================================================
// trng_ctrl: warm-up discard, repetition-count health test and stream delivery
// for the 32-bit TRNG collector. Option macro: TRNG_CTRL_WHITEN_EN.
// Revision: 1.0
// ==========================================================================
module trng_ctrl #(
  parameter int WARMUP_WORDS = 4,
  parameter int RCT_LIMIT    = 3,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] num_words,
  input  logic             clear_fail,
  output logic             core_enable,
  input  logic [31:0]      core_data,
  input  logic             core_valid,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             health_fail,
  output logic [CNT_W-1:0] words_left
);

  localparam int WC_W = $clog2(WARMUP_WORDS + 1);
  localparam int RC_W = $clog2(RCT_LIMIT + 1);

  localparam logic [WC_W-1:0]  C_WARM_LAST = WC_W'(WARMUP_WORDS - 1);
  localparam logic [RC_W-1:0]  C_RCT_MAX   = RC_W'(RCT_LIMIT);
  localparam logic [RC_W-1:0]  C_RCT_ONE   = RC_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WARMUP  = 3'd1;
  localparam logic [2:0] S_COLLECT = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_FAIL    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WC_W-1:0]  warm_cnt_q, warm_cnt_d;
  logic [RC_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic [31:0]      prev_raw_q, prev_raw_d;
  logic             stop_pend_q, stop_pend_d;
  logic [CNT_W-1:0] words_left_q, words_left_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             core_enable_q, core_enable_d;
  logic             health_fail_q, health_fail_d;

  logic             raw_repeat;
  logic [RC_W-1:0]  rep_next;
  logic             health_ok;
  logic             handshake;
  logic [31:0]      deliver_word;

  assign handshake  = out_valid_q & out_ready;
  assign raw_repeat = (core_data == prev_raw_q);
  assign rep_next   = !raw_repeat ? C_RCT_ONE :
                      (rep_cnt_q >= C_RCT_MAX) ? C_RCT_MAX : rep_cnt_q + 1'b1;
  assign health_ok  = !(raw_repeat && (rep_next >= C_RCT_MAX));

`ifdef TRNG_CTRL_WHITEN_EN
  // Each delivered word is chained onto the previous one; health test stays on raw data.
  logic [31:0] last_q;
  assign deliver_word = core_data ^ last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= '0;
    end else if (handshake) begin
      last_q <= out_data_q;
    end
  end
`else
  assign deliver_word = core_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      warm_cnt_q    <= '0;
      rep_cnt_q     <= '0;
      prev_raw_q    <= '0;
      stop_pend_q   <= 1'b0;
      words_left_q  <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      core_enable_q <= 1'b0;
      health_fail_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      warm_cnt_q    <= warm_cnt_d;
      rep_cnt_q     <= rep_cnt_d;
      prev_raw_q    <= prev_raw_d;
      stop_pend_q   <= stop_pend_d;
      words_left_q  <= words_left_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
      core_enable_q <= core_enable_d;
      health_fail_q <= health_fail_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    warm_cnt_d   = warm_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    prev_raw_d   = prev_raw_q;
    stop_pend_d  = stop_pend_q;
    words_left_d = words_left_q;
    out_data_d   = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d      = S_WARMUP;
          words_left_d = num_words;
          warm_cnt_d   = '0;
          rep_cnt_d    = '0;
          stop_pend_d  = 1'b0;
        end
      end
      S_WARMUP, S_COLLECT: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (core_valid) begin
          rep_cnt_d  = rep_next;
          prev_raw_d = core_data;
          if (!health_ok) begin
            state_d = S_FAIL;
          end else if (state_q == S_WARMUP) begin
            warm_cnt_d = warm_cnt_q + 1'b1;
            if (warm_cnt_q == C_WARM_LAST) state_d = S_COLLECT;
          end else begin
            out_data_d = deliver_word;
            state_d    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (stop) stop_pend_d = 1'b1;
        if (out_ready) begin
          // words_left of zero marks continuous mode and is never decremented.
          if (words_left_q != '0) words_left_d = words_left_q - 1'b1;
          if ((words_left_q == C_CNT_ONE) || stop_pend_q || stop) begin
            state_d     = S_IDLE;
            stop_pend_d = 1'b0;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_FAIL: begin
        if (clear_fail) begin
          state_d   = S_IDLE;
          rep_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    core_enable_d = (state_d == S_WARMUP) || (state_d == S_COLLECT);
    busy_d        = (state_d == S_WARMUP) || (state_d == S_COLLECT) || (state_d == S_HOLD);
    out_valid_d   = (state_d == S_HOLD);
    health_fail_d = (state_d == S_FAIL);
  end

  assign core_enable = core_enable_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign health_fail = health_fail_q;
  assign words_left  = words_left_q;

endmodule
`default_nettype wire

// File: tb/tb_trng_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_trng_ctrl: directed self-checking bench with a behavioural word collector.
// Revision: 1.0
// ==========================================================================
module tb_trng_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, stop, clear_fail, out_ready;
  logic [CNT_W-1:0] num_words;
  logic             core_enable, core_valid;
  logic [31:0]      core_data, out_data;
  logic             out_valid, busy, health_fail;
  logic [CNT_W-1:0] words_left;

  trng_ctrl #(.WARMUP_WORDS(4), .RCT_LIMIT(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .num_words(num_words),
    .clear_fail(clear_fail), .core_enable(core_enable), .core_data(core_data),
    .core_valid(core_valid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .health_fail(health_fail),
    .words_left(words_left)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] seq [0:7];
  int          seq_idx = 0;
  int          col_cnt = 0;
  logic [31:0] tb_last = '0;
  logic [31:0] hs_data [0:3];
  int          hs_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Collector model: one word 32 cycles after enable, restarting whenever enable drops.
  initial begin
    core_valid = 1'b0;
    core_data  = '0;
    forever begin
      @(negedge clk);
      core_valid = 1'b0;
      if (!core_enable) begin
        col_cnt = 0;
      end else begin
        col_cnt++;
        if (col_cnt == 32) begin
          col_cnt    = 0;
          core_valid = 1'b1;
          core_data  = seq[seq_idx];
          if (seq_idx < 7) seq_idx++;
        end
      end
    end
  end

  function automatic logic [31:0] model_out(input logic [31:0] raw);
    logic [31:0] r;
`ifdef TRNG_CTRL_WHITEN_EN
    r = raw ^ tb_last;
    tb_last = r;
`else
    r = raw;
`endif
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load6(input logic [31:0] w0, w1, w2, w3, w4, w5);
    seq[0] = w0; seq[1] = w1; seq[2] = w2; seq[3] = w3; seq[4] = w4; seq[5] = w5;
    seq[6] = 32'h7777_7777; seq[7] = 32'h8888_8888;
    seq_idx = 0;
  endtask

  task automatic pulse_start(input logic [CNT_W-1:0] n);
    num_words = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    int k = 0;
    while (!out_valid && k < max_cycles) begin
      tick();
      k++;
    end
    check({tag, " valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic run_collect(input int n_cycles);
    for (int i = 0; i < n_cycles; i++) begin
      if (out_valid && out_ready && hs_cnt < 4) begin
        hs_data[hs_cnt] = out_data;
        hs_cnt++;
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] e0, e1;
    bit          stable, seen;

    rst = 1'b1; start = 1'b0; stop = 1'b0; clear_fail = 1'b0;
    out_ready = 1'b0; num_words = '0;
    #1;
    check("rst out_valid",   {31'd0, out_valid},   32'd0);
    check("rst busy",        {31'd0, busy},        32'd0);
    check("rst core_enable", {31'd0, core_enable}, 32'd0);
    check("rst health_fail", {31'd0, health_fail}, 32'd0);
    check("rst words_left",  {24'd0, words_left},  32'd0);
    check("rst out_data",    out_data,             32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Counted mode: two words after four warm-up words.
    load6(32'h1111_0001, 32'h1111_0002, 32'h1111_0003, 32'h1111_0004,
          32'hA5A5_0005, 32'hA5A5_0006);
    out_ready = 1'b1;
    pulse_start(8'd2);
    check("t1 busy",        {31'd0, busy},        32'd1);
    check("t1 core_enable", {31'd0, core_enable}, 32'd1);
    check("t1 words_left",  {24'd0, words_left},  32'd2);
    hs_cnt = 0;
    run_collect(300);
    e0 = model_out(32'hA5A5_0005);
    e1 = model_out(32'hA5A5_0006);
    check("t1 hs count",    hs_cnt,               32'd2);
    check("t1 word0",       hs_data[0],           e0);
    check("t1 word1",       hs_data[1],           e1);
    check("t1 busy end",    {31'd0, busy},        32'd0);
    check("t1 words_left0", {24'd0, words_left},  32'd0);
    check("t1 enable end",  {31'd0, core_enable}, 32'd0);

    // Back-pressure in HOLD.
    load6(32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hB000_0004,
          32'hB000_0005, 32'hB000_0006);
    out_ready = 1'b0;
    pulse_start(8'd1);
    wait_valid("t2", 300);
    d = out_data;
    e0 = model_out(32'hB000_0005);
    check("t2 data", d, e0);
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== d || core_enable !== 1'b0) stable = 1'b0;
    end
    check("t2 hold stable", {31'd0, stable}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t2 valid drop", {31'd0, out_valid},  32'd0);
    check("t2 busy drop",  {31'd0, busy},       32'd0);
    check("t2 words_left", {24'd0, words_left}, 32'd0);

    // Repetition-count failure: third identical raw word lands in COLLECT.
    load6(32'hC000_0001, 32'hC000_0002, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
          32'hDEAD_BEEF, 32'hC000_0006);
    out_ready = 1'b1;
    pulse_start(8'd0);
    hs_cnt = 0;
    run_collect(250);
    check("t3 no delivery", hs_cnt,                32'd0);
    check("t3 health_fail", {31'd0, health_fail},  32'd1);
    check("t3 busy",        {31'd0, busy},         32'd0);
    check("t3 enable",      {31'd0, core_enable},  32'd0);
    check("t3 valid",       {31'd0, out_valid},    32'd0);
    pulse_start(8'd3);
    check("t3 start ignored", {31'd0, busy},        32'd0);
    check("t3 still failed",  {31'd0, health_fail}, 32'd1);
    clear_fail = 1'b1;
    tick();
    clear_fail = 1'b0;
    check("t3 cleared",      {31'd0, health_fail}, 32'd0);
    check("t3 idle busy",    {31'd0, busy},        32'd0);

    // Continuous mode, stop while holding a word.
    load6(32'hD000_0001, 32'hD000_0002, 32'hD000_0003, 32'hD000_0004,
          32'hD000_0005, 32'hD000_0006);
    out_ready = 1'b0;
    pulse_start(8'd0);
    check("t4 words_left cont", {24'd0, words_left}, 32'd0);
    wait_valid("t4a", 300);
    d = out_data;
    e0 = model_out(32'hD000_0005);
    check("t4a data", d, e0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4a held valid", {31'd0, out_valid}, 32'd1);
    check("t4a held busy",  {31'd0, busy},      32'd1);
    check("t4a held data",  out_data,           d);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4a valid drop", {31'd0, out_valid}, 32'd0);
    check("t4a idle",       {31'd0, busy},      32'd0);

    // Continuous mode, stop while collecting.
    load6(32'hE000_0001, 32'hE000_0002, 32'hE000_0003, 32'hE000_0004,
          32'hE000_0005, 32'hE000_0006);
    out_ready = 1'b1;
    pulse_start(8'd0);
    wait_valid("t4b", 300);
    e0 = model_out(32'hE000_0005);
    check("t4b data", out_data, e0);
    tick();
    check("t4b collect valid",  {31'd0, out_valid},   32'd0);
    check("t4b collect enable", {31'd0, core_enable}, 32'd1);
    repeat (5) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4b stop busy",   {31'd0, busy},        32'd0);
    check("t4b stop enable", {31'd0, core_enable}, 32'd0);
    seen = 1'b0;
    repeat (60) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("t4b no valid", {31'd0, seen}, 32'd0);

    // Asynchronous reset while holding a word.
    load6(32'hF000_0001, 32'hF000_0002, 32'hF000_0003, 32'hF000_0004,
          32'hF000_0005, 32'hF000_0006);
    out_ready = 1'b0;
    pulse_start(8'd1);
    wait_valid("t5", 300);
    #2;
    rst = 1'b1;
    #1;
    check("t5 async valid",  {31'd0, out_valid},   32'd0);
    check("t5 async busy",   {31'd0, busy},        32'd0);
    check("t5 async enable", {31'd0, core_enable}, 32'd0);
    check("t5 async data",   out_data,             32'd0);
    tb_last = '0;
    tick();
    rst = 1'b0;
    tick();

    // Two chosen raw words delivered after a fresh reset.
    load6(32'h9000_0001, 32'h9000_0002, 32'h9000_0003, 32'h9000_0004,
          32'h0000_FFFF, 32'h00FF_00FF);
    out_ready = 1'b1;
    pulse_start(8'd2);
    hs_cnt = 0;
    run_collect(300);
    check("t6 hs count", hs_cnt,     32'd2);
    check("t6 word0",    hs_data[0], 32'h0000_FFFF);
`ifdef TRNG_CTRL_WHITEN_EN
    check("t6 word1",    hs_data[1], 32'h00FF_FF00);
`else
    check("t6 word1",    hs_data[1], 32'h00FF_00FF);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
